// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, types and helpers for the clk_div_n divider.
//   DIV_W_DEF  default divisor/counter width
//   DIV_MIN    smallest divisor accepted on a load
//   run_st_e   run/idle state of the period generator
//   half()     high-phase length (in whole cycles) for a divisor
`timescale 1ns/1ps
package clk_div_pkg;

   localparam int unsigned DIV_W_DEF = 8;
   localparam int unsigned DIV_MIN   = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } run_st_e;

   function automatic logic [31:0] half(input logic [31:0] div);
      return div >> 1;
   endfunction

endpackage

// File: rtl/clk_div_neg_ff.sv
// clk_div_neg_ff: single negedge flop with asynchronous active-high reset.
// Kept in its own module so the half-cycle path has one place to constrain.
// Ports:
//   i_clk  source clock (captures on falling edge)
//   i_rst  asynchronous active-high reset, clears o_q
//   i_d    data in
//   o_q    registered data out
`timescale 1ns/1ps
module clk_div_neg_ff
   import clk_div_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_q;

   always_ff @(negedge i_clk or posedge i_rst) begin
      if (i_rst) r_q <= 1'b0;
      else       r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/clk_div_n.sv
// clk_div_n: run-time programmable integer clock divider, y = clk/N with 50%
// duty for odd and even N. Divisor and enable changes apply only at a period
// boundary (the posedge where the counter wraps to 0), so y never glitches.
// Optional macro CLK_DIV_TICK_EN adds the 'tick' output (one-cycle pulse at
// each boundary, aligned with the rising edge of y).
// Ports:
//   clk       source clock
//   rst       asynchronous active-high reset
//   en        run enable
//   div_i     requested divisor
//   div_load  strobe capturing div_i into the pending divisor
//   y         divided clock
//   div_o     divisor currently in effect
//   load_err  one-cycle pulse after a rejected load (div_i < 2)
//   running   high while periods are being generated
//   tick      (CLK_DIV_TICK_EN only) boundary pulse
`timescale 1ns/1ps
module clk_div_n
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W       = DIV_W_DEF,
   parameter int unsigned DIV_DEFAULT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div_i,
   input  logic             div_load,
   output logic             y,
   output logic [DIV_W-1:0] div_o,
   output logic             load_err,
   output logic             running
`ifdef CLK_DIV_TICK_EN
  ,output logic             tick
`endif
);

   typedef logic [DIV_W-1:0] div_t;

   localparam div_t DEF = div_t'(DIV_DEFAULT);
   localparam div_t ONE = div_t'(1);
   localparam div_t MIN = div_t'(DIV_MIN);

   div_t    r_cnt;
   div_t    r_div_act;
   div_t    r_div_pend;
   logic    r_pend_vld;
   logic    r_q_pos;
   logic    r_load_err;
   run_st_e r_state;

   div_t    w_cnt_nxt;
   div_t    w_div_act_nxt;
   div_t    w_half_nxt;
   logic    w_last;
   logic    w_adv;
   logic    w_boundary;
   logic    w_load_ok;
   logic    w_q_neg;
   run_st_e w_state_nxt;

   always_comb begin
      w_last     = (r_cnt == r_div_act - ONE);
      // With en low the counter still runs to the end of the period, then parks.
      w_adv      = en | ~w_last;
      w_boundary = w_adv & w_last;
      w_cnt_nxt  = r_cnt;
      if (w_adv) w_cnt_nxt = w_last ? '0 : r_cnt + ONE;
      // The new divisor governs the period starting at this edge, so the
      // waveform compare uses the post-boundary divisor.
      w_div_act_nxt = (w_boundary && r_pend_vld) ? r_div_pend : r_div_act;
      w_half_nxt    = div_t'(half(32'(w_div_act_nxt)));
      w_load_ok     = div_load && (div_i >= MIN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= DEF - ONE;
         r_div_act  <= DEF;
         r_div_pend <= DEF;
         r_pend_vld <= 1'b0;
         r_q_pos    <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_div_act  <= w_div_act_nxt;
         r_q_pos    <= (w_cnt_nxt < w_half_nxt);
         r_load_err <= div_load & ~w_load_ok;
         // A load on a boundary edge stays pending for the following boundary.
         if (w_load_ok) begin
            r_div_pend <= div_i;
            r_pend_vld <= 1'b1;
         end else if (w_boundary) begin
            r_pend_vld <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_boundary) w_state_nxt = ST_RUN;
         ST_RUN:  if (!w_adv)     w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   clk_div_neg_ff u_neg_ff (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (r_q_pos),
      .o_q   (w_q_neg)
   );

   // Odd N stretches the high phase by half a cycle using the negedge copy.
   assign y        = r_div_act[0] ? (r_q_pos | w_q_neg) : r_q_pos;
   assign div_o    = r_div_act;
   assign load_err = r_load_err;
   assign running  = (r_state == ST_RUN);

`ifdef CLK_DIV_TICK_EN
   logic r_tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_tick <= 1'b0;
      else     r_tick <= w_boundary;
   end

   assign tick = r_tick;
`endif

endmodule

// File: tb/tb_clk_div_n.sv
// tb_clk_div_n: self-checking bench for clk_div_n. Measures y rise/fall
// times and compares periods, high times and divisor updates against the
// divisor sequence expected from the loads applied.
`timescale 1ns/1ps
module tb_clk_div_n;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [7:0] div_i = '0;
   logic       div_load = 1'b0;
   logic       y;
   logic [7:0] div_o;
   logic       load_err;
   logic       running;
`ifdef CLK_DIV_TICK_EN
   logic       tick;
`endif

   int  n_cmp = 0;
   int  n_err = 0;
   int  cur_n = 3;
   int  rise_cnt = 0;
   time last_rise = 0;
   time prev_rise = 0;
   time last_fall = 0;

   clk_div_n #(.DIV_W(8), .DIV_DEFAULT(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .div_i    (div_i),
      .div_load (div_load),
      .y        (y),
      .div_o    (div_o),
      .load_err (load_err),
      .running  (running)
`ifdef CLK_DIV_TICK_EN
     ,.tick     (tick)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge y) begin
      prev_rise = last_rise;
      last_rise = $time;
      rise_cnt++;
   end

   always @(negedge y) last_fall = $time;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic wait_rise(input int budget, output time t, output bit ok);
      int start;
      start = rise_cnt;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (rise_cnt != start) begin
            ok = 1'b1;
            break;
         end
      end
      t = last_rise;
   endtask

   task automatic drive_load(input int v);
      @(posedge clk);
      #2;
      div_i = 8'(v);
      div_load = 1'b1;
      @(posedge clk);
      #1;
      div_load = 1'b0;
   endtask

   task automatic test_reset();
      time t, tprev, t0;
      bit  ok;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (y !== 1'b0) begin n_err++; $display("FAIL reset_y: got %b want 0", y); end
      n_cmp++; if (div_o !== 8'd3) begin n_err++; $display("FAIL reset_div_o: got %0d want 3", div_o); end
      n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL reset_load_err: got %b want 0", load_err); end
      n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", running); end
`ifdef CLK_DIV_TICK_EN
      n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", tick); end
`endif
      en = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if (y !== 1'b0) begin n_err++; $display("FAIL reset_hold_y: got %b want 0", y); end
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (y !== 1'b1) begin n_err++; $display("FAIL first_rise_y: got %b want 1", y); end
      n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL first_rise_running: got %b want 1", running); end
      tprev = last_rise;
      t0 = last_rise;
      for (int i = 0; i < 10; i++) begin
         wait_rise(5, t, ok);
         n_cmp++; if (!ok) begin n_err++; $display("FAIL n3_timeout: got no rise want rise"); end
         n_cmp++; if (t - tprev != time'(30)) begin n_err++; $display("FAIL n3_period: got %0d want 30", t - tprev); end
         n_cmp++; if (last_fall - tprev != time'(15)) begin n_err++; $display("FAIL n3_high: got %0d want 15", last_fall - tprev); end
         tprev = t;
      end
      n_cmp++; if (tprev - t0 != time'(300)) begin n_err++; $display("FAIL n3_total: got %0d want 300", tprev - t0); end
      cur_n = 3;
   endtask

   task automatic load_and_check(input int n, input string tag);
      time t_new, t2;
      bit  ok;
      int  old;
      old = cur_n;
      repeat ($urandom_range(0, old - 1)) @(posedge clk);
      drive_load(n);
      n_cmp++; if (div_o !== 8'(old)) begin n_err++; $display("FAIL %s_div_o_hold: got %0d want %0d", tag, div_o, old); end
      wait_rise(old + 2, t_new, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL %s_timeout1: got no rise want rise", tag); end
      n_cmp++; if (div_o !== 8'(n)) begin n_err++; $display("FAIL %s_div_o_new: got %0d want %0d", tag, div_o, n); end
      n_cmp++; if (t_new - prev_rise != time'(old * 10)) begin n_err++; $display("FAIL %s_old_period: got %0d want %0d", tag, t_new - prev_rise, old * 10); end
      wait_rise(n + 2, t2, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL %s_timeout2: got no rise want rise", tag); end
      n_cmp++; if (t2 - t_new != time'(n * 10)) begin n_err++; $display("FAIL %s_period: got %0d want %0d", tag, t2 - t_new, n * 10); end
      n_cmp++; if (last_fall - t_new != time'(n * 5)) begin n_err++; $display("FAIL %s_high: got %0d want %0d", tag, last_fall - t_new, n * 5); end
      cur_n = n;
   endtask

   task automatic test_program();
      int seq [5] = '{4, 8, 255, 3, 5};
      for (int i = 0; i < 5; i++) load_and_check(seq[i], "prog");
      for (int i = 0; i < 5; i++) load_and_check(int'($urandom_range(2, 40)), "rand");
   endtask

   task automatic test_load_err();
      int  bad [2] = '{1, 0};
      time t1, t2;
      bit  ok;
      for (int i = 0; i < 2; i++) begin
         drive_load(bad[i]);
         n_cmp++; if (load_err !== 1'b1) begin n_err++; $display("FAIL load_err_pulse: got %b want 1", load_err); end
         @(posedge clk);
         #1;
         n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL load_err_clear: got %b want 0", load_err); end
         n_cmp++; if (div_o !== 8'(cur_n)) begin n_err++; $display("FAIL load_err_div_o: got %0d want %0d", div_o, cur_n); end
      end
      wait_rise(cur_n + 2, t1, ok);
      wait_rise(cur_n + 2, t2, ok);
      n_cmp++; if (t2 - t1 != time'(cur_n * 10)) begin n_err++; $display("FAIL load_err_period: got %0d want %0d", t2 - t1, cur_n * 10); end
      n_cmp++; if (div_o !== 8'(cur_n)) begin n_err++; $display("FAIL load_err_div_o_after: got %0d want %0d", div_o, cur_n); end
   endtask

   task automatic test_back_to_back();
      time t0, t_new, t2;
      bit  ok;
      int  a, b;
      load_and_check(9, "b2b_pre");
      a = int'($urandom_range(2, 60));
      b = int'($urandom_range(2, 60));
      wait_rise(cur_n + 2, t0, ok);
      drive_load(a);
      drive_load(b);
      wait_rise(cur_n + 2, t_new, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_timeout: got no rise want rise"); end
      n_cmp++; if (t_new - t0 != time'(90)) begin n_err++; $display("FAIL b2b_old_period: got %0d want 90", t_new - t0); end
      n_cmp++; if (div_o !== 8'(b)) begin n_err++; $display("FAIL b2b_last_wins: got %0d want %0d", div_o, b); end
      wait_rise(b + 2, t2, ok);
      n_cmp++; if (t2 - t_new != time'(b * 10)) begin n_err++; $display("FAIL b2b_period: got %0d want %0d", t2 - t_new, b * 10); end
      cur_n = b;
   endtask

   task automatic test_enable();
      time t0, t;
      bit  ok;
      int  rc;
      load_and_check(7, "en_pre");
      wait_rise(cur_n + 2, t0, ok);
      #1;
      en = 1'b0;
      #((t0 + time'(cur_n * 10 - 5)) - $time);
      n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL en_running_tail: got %b want 1", running); end
      #6;
      n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL en_running_idle: got %b want 0", running); end
      n_cmp++; if (y !== 1'b0) begin n_err++; $display("FAIL en_y_idle: got %b want 0", y); end
      n_cmp++; if (last_fall - t0 != time'(cur_n * 5)) begin n_err++; $display("FAIL en_last_high: got %0d want %0d", last_fall - t0, cur_n * 5); end
      rc = rise_cnt;
      repeat (20) @(posedge clk);
      #1;
      n_cmp++; if (rise_cnt != rc) begin n_err++; $display("FAIL en_idle_rises: got %0d want %0d", rise_cnt, rc); end
      n_cmp++; if (y !== 1'b0 || running !== 1'b0) begin n_err++; $display("FAIL en_idle_state: got y=%b run=%b want 0 0", y, running); end
`ifdef CLK_DIV_TICK_EN
      n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL en_idle_tick: got %b want 0", tick); end
`endif
      #1;
      en = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if (y !== 1'b1 || running !== 1'b1) begin n_err++; $display("FAIL en_restart: got y=%b run=%b want 1 1", y, running); end
      t0 = last_rise;
      wait_rise(cur_n + 2, t, ok);
      n_cmp++; if (t - t0 != time'(cur_n * 10)) begin n_err++; $display("FAIL en_restart_period: got %0d want %0d", t - t0, cur_n * 10); end
   endtask

   task automatic test_reset_mid();
      time t, tprev;
      bit  ok;
      wait_rise(cur_n + 2, t, ok);
      #3;
      rst = 1'b1;
      #1;
      n_cmp++; if (y !== 1'b0) begin n_err++; $display("FAIL rst_mid_y: got %b want 0", y); end
      n_cmp++; if (div_o !== 8'd3) begin n_err++; $display("FAIL rst_mid_div_o: got %0d want 3", div_o); end
      n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL rst_mid_running: got %b want 0", running); end
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (y !== 1'b1) begin n_err++; $display("FAIL rst_release_rise: got %b want 1", y); end
      cur_n = 3;
      tprev = last_rise;
      for (int i = 0; i < 4; i++) begin
`ifdef CLK_DIV_TICK_EN
         n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL tick_high: got %b want 1", tick); end
         @(posedge clk);
         #1;
         n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL tick_low: got %b want 0", tick); end
`endif
         wait_rise(5, t, ok);
         n_cmp++; if (t - tprev != time'(30)) begin n_err++; $display("FAIL rst_post_period: got %0d want 30", t - tprev); end
         tprev = t;
      end
   endtask

   initial begin
      test_reset();
      test_program();
      test_load_err();
      test_back_to_back();
      test_enable();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
